intctl: RTL and testbench

- Interrupt controller directly downstream of the countdown timer (cdtimer); source 0 is wired to the timer's `timeout` output.
- Edge-detects level interrupt sources, latches them as pending and masks them with a CPU-writable enable register.
- Presents one interrupt at a time to the CPU through an irq/iack/eoi handshake.
- Also exposes a small register interface so software can mask, clear and inspect interrupts.

---
 rtl/intctl.sv | 122 ++++++++++++
 tb/tb_intctl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/intctl.sv
// Interrupt controller: edge-detected sources latched as pending, masked by an
// enable register, and presented one at a time over an irq/iack/eoi handshake.
module intctl #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic               wr_en,
  input  logic [1:0]         addr,
  input  logic [WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]   rd_data,
  output logic               irq,
  output logic [3:0]         irq_num,
  input  logic               iack,
  input  logic               eoi
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [1:0]         state_q, state_d;
  logic [3:0]         irq_num_q, irq_num_d;

  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] cur_mask;
  logic [3:0]         sel_num;
  logic               wr_ena;
  logic               wr_pnd;
  logic               unused_wr;

  assign edges  = src & ~src_prev_q;
  assign req    = pending_q & enable_q;
  assign wr_ena = wr_en && (addr == 2'd0);
  assign wr_pnd = wr_en && (addr == 2'd1);

  // Only the low NUM_SRC bits of write data are meaningful.
  assign unused_wr = ^wr_data;

  always_comb begin
    sel_num = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (req[i-1]) sel_num = 4'(i - 1);
    end
  end

  always_comb begin
    cur_mask = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cur_mask[i] = (irq_num_q == 4'(i));
    end
  end

  always_comb begin
    enable_d = wr_ena ? wr_data[NUM_SRC-1:0] : enable_q;
  end

  // Clears are applied first so a same-cycle rising edge always wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_pnd) pending_d = pending_d & ~wr_data[NUM_SRC-1:0];
    if (state_q == ST_REQ && iack) pending_d = pending_d & ~cur_mask;
    pending_d = pending_d | edges;
  end

  always_comb begin
    state_d   = state_q;
    irq_num_d = irq_num_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_REQ;
          irq_num_d = sel_num;
        end
      end
      ST_REQ: begin
        // Withdraw looks at next-cycle pending/enable so the drop and the
        // return to IDLE happen on the same edge.
        if (iack) state_d = ST_BUSY;
        else if ((pending_d & enable_d & cur_mask) == '0) state_d = ST_IDLE;
      end
      ST_BUSY: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    src_prev_q <= src;
    if (rst) begin
      pending_q <= '0;
      enable_q  <= '0;
      state_q   <= ST_IDLE;
      irq_num_q <= '0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      state_q   <= state_d;
      irq_num_q <= irq_num_d;
    end
  end

  assign irq     = (state_q == ST_REQ);
  assign irq_num = irq_num_q;

  always_comb begin
    case (addr)
      2'd0:    rd_data = WIDTH'(enable_q);
      2'd1:    rd_data = WIDTH'(pending_q);
      2'd2:    rd_data = WIDTH'({state_q, irq_num_q});
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_intctl.sv
// Scoreboard bench for intctl: expectations are queued with each stimulus step
// and checked against the DUT just after the following clock edge.
module tb_intctl;

  localparam int K_ENA = 0;
  localparam int K_PND = 1;
  localparam int K_STA = 2;
  localparam int K_A3  = 3;
  localparam int K_IRQ = 4;
  localparam int K_NUM = 5;

  typedef struct {
    string       tag;
    int          kind;
    logic [15:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src;
  logic        wr_en;
  logic [1:0]  addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        irq;
  logic [3:0]  irq_num;
  logic        iack;
  logic        eoi;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  intctl #(.NUM_SRC(4), .WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .src     (src),
    .wr_en   (wr_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq     (irq),
    .irq_num (irq_num),
    .iack    (iack),
    .eoi     (eoi)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_val(input string tag, input int kind, input logic [15:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] got;
    wr_en = 1'b0;
    iack  = 1'b0;
    eoi   = 1'b0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.kind == K_IRQ) got = 16'(irq);
      else if (e.kind == K_NUM) got = 16'(irq_num);
      else begin
        addr = 2'(e.kind);
        #1;
        got = rd_data;
      end
      check_val(e.tag, got, e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    drain();
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    addr    = a;
    wr_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; src = '0; wr_en = 1'b0; addr = '0; wr_data = '0; iack = 1'b0; eoi = 1'b0;
    cyc();
    expect_val("rst_irq", K_IRQ, 16'h0);
    expect_val("rst_num", K_NUM, 16'h0);
    expect_val("rst_ena", K_ENA, 16'h0);
    expect_val("rst_pnd", K_PND, 16'h0);
    expect_val("rst_sta", K_STA, 16'h0);
    expect_val("rst_a3",  K_A3,  16'h0);
    cyc();
    rst = 1'b0;

    // Timer path: src[0] stands in for the cdtimer timeout.
    wr(2'd0, 16'h1); expect_val("tmr_ena", K_ENA, 16'h1); cyc();
    src[0] = 1'b1;
    expect_val("tmr_pnd", K_PND, 16'h1); expect_val("tmr_irq_lat", K_IRQ, 16'h0); cyc();
    expect_val("tmr_irq", K_IRQ, 16'h1); expect_val("tmr_num", K_NUM, 16'h0);
    expect_val("tmr_sta_req", K_STA, 16'h10); cyc();
    iack = 1'b1;
    expect_val("tmr_ack_pnd", K_PND, 16'h0); expect_val("tmr_ack_sta", K_STA, 16'h20);
    expect_val("tmr_ack_irq", K_IRQ, 16'h0); cyc();
    eoi = 1'b1;
    expect_val("tmr_eoi_sta", K_STA, 16'h0); expect_val("tmr_eoi_irq", K_IRQ, 16'h0); cyc();

    // Level held high: no re-trigger.
    for (int i = 0; i < 3; i++) begin
      expect_val("hold_irq", K_IRQ, 16'h0); expect_val("hold_pnd", K_PND, 16'h0); cyc();
    end
    src[0] = 1'b0; cyc();
    src[0] = 1'b1; expect_val("reload_pnd", K_PND, 16'h1); cyc();
    expect_val("reload_irq", K_IRQ, 16'h1); expect_val("reload_num", K_NUM, 16'h0); cyc();
    iack = 1'b1; cyc();
    eoi = 1'b1; expect_val("reload_eoi_sta", K_STA, 16'h0); cyc();
    src[0] = 1'b0;

    // Masking.
    wr(2'd0, 16'h0); expect_val("mask_ena0", K_ENA, 16'h0); cyc();
    src[2] = 1'b1;
    expect_val("mask_pnd", K_PND, 16'h4); expect_val("mask_irq0", K_IRQ, 16'h0); cyc();
    expect_val("mask_irq1", K_IRQ, 16'h0); cyc();
    wr(2'd0, 16'h4); expect_val("mask_ena4", K_ENA, 16'h4); expect_val("mask_irq2", K_IRQ, 16'h0); cyc();
    expect_val("mask_irq", K_IRQ, 16'h1); expect_val("mask_num", K_NUM, 16'h2); cyc();
    iack = 1'b1; cyc();
    eoi = 1'b1; expect_val("mask_eoi_sta", K_STA, 16'h02); cyc();
    src = '0;

    // Priority and no preemption.
    wr(2'd0, 16'hF); cyc();
    src = 4'b1010; expect_val("pri_pnd", K_PND, 16'hA); cyc();
    expect_val("pri_irq", K_IRQ, 16'h1); expect_val("pri_num1", K_NUM, 16'h1); cyc();
    iack = 1'b1;
    expect_val("pri_ack_pnd", K_PND, 16'h8); expect_val("pri_ack_sta", K_STA, 16'h21); cyc();
    src[0] = 1'b1;
    expect_val("nopre_pnd", K_PND, 16'h9); expect_val("nopre_irq", K_IRQ, 16'h0);
    expect_val("nopre_sta", K_STA, 16'h21); cyc();
    expect_val("nopre_sta2", K_STA, 16'h21); cyc();
    eoi = 1'b1; expect_val("pri_eoi_sta", K_STA, 16'h01); cyc();
    expect_val("pri_irq0", K_IRQ, 16'h1); expect_val("pri_num0", K_NUM, 16'h0); cyc();
    iack = 1'b1; expect_val("pri_pnd8", K_PND, 16'h8); cyc();
    eoi = 1'b1; cyc();
    expect_val("pri_irq3", K_IRQ, 16'h1); expect_val("pri_num3", K_NUM, 16'h3); cyc();
    iack = 1'b1; expect_val("pri_pnd0", K_PND, 16'h0); cyc();
    eoi = 1'b1; expect_val("pri_end_sta", K_STA, 16'h03); cyc();
    src = '0; cyc();

    // Withdraw by W1C while requesting.
    src = 4'b0010; expect_val("wd_pnd", K_PND, 16'h2); cyc();
    expect_val("wd_irq", K_IRQ, 16'h1); expect_val("wd_num", K_NUM, 16'h1); cyc();
    wr(2'd1, 16'h2);
    expect_val("wd_irq0", K_IRQ, 16'h0); expect_val("wd_sta", K_STA, 16'h01);
    expect_val("wd_pnd0", K_PND, 16'h0); cyc();
    expect_val("wd_irq_after", K_IRQ, 16'h0); cyc();

    // W1C racing a new edge on the same bit.
    src[2] = 1'b1; wr(2'd1, 16'h4); expect_val("race_w1c_pnd", K_PND, 16'h4); cyc();
    expect_val("race_irq", K_IRQ, 16'h1); expect_val("race_num", K_NUM, 16'h2); cyc();
    iack = 1'b1; expect_val("race_ack_pnd", K_PND, 16'h0); expect_val("race_ack_sta", K_STA, 16'h22); cyc();
    src[3] = 1'b1; expect_val("busy_pnd8", K_PND, 16'h8); expect_val("busy_sta", K_STA, 16'h22); cyc();

    // Reset while BUSY, sources held high across release.
    rst = 1'b1;
    expect_val("mrst_irq", K_IRQ, 16'h0); expect_val("mrst_pnd", K_PND, 16'h0);
    expect_val("mrst_ena", K_ENA, 16'h0); expect_val("mrst_sta", K_STA, 16'h0); cyc();
    rst = 1'b0;
    expect_val("rel_pnd", K_PND, 16'h0); expect_val("rel_irq", K_IRQ, 16'h0); cyc();
    wr(2'd3, 16'hFFFF);
    expect_val("a3_ena", K_ENA, 16'h0); expect_val("a3_pnd", K_PND, 16'h0); expect_val("a3_rd", K_A3, 16'h0); cyc();

    // Stray iack/eoi in IDLE are ignored.
    wr(2'd0, 16'hF); cyc();
    iack = 1'b1; eoi = 1'b1;
    expect_val("stray_sta", K_STA, 16'h0); expect_val("stray_irq", K_IRQ, 16'h0); cyc();

    // New edge together with the iack clear of the same bit.
    src = '0; cyc();
    src[1] = 1'b1; expect_val("ackrace_pnd", K_PND, 16'h2); cyc();
    expect_val("ackrace_irq", K_IRQ, 16'h1); expect_val("ackrace_num", K_NUM, 16'h1); cyc();
    src[1] = 1'b0; expect_val("ackrace_hold", K_IRQ, 16'h1); cyc();
    src[1] = 1'b1; iack = 1'b1;
    expect_val("ackrace_set", K_PND, 16'h2); expect_val("ackrace_sta", K_STA, 16'h21); cyc();
    eoi = 1'b1; expect_val("ackrace_eoi", K_STA, 16'h01); cyc();
    expect_val("ackrace_reirq", K_IRQ, 16'h1); expect_val("ackrace_renum", K_NUM, 16'h1); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
